// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbitration path: byte width and the
// arbiter state encoding.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin priority encoder: the winner is the first set
// request found searching upward from ptr_i+1, wrapping around.
module uart_rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  winner_o,
    output logic          any_o
);

    logic          found;
    logic [PW-1:0] idx;

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(ptr_i) + i) % N);
            if (!found && req_i[idx]) begin
                winner_o[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-wise round-robin arbiter sharing one UART transmitter between
// N_REQ requesters, with a forced release after MAX_BURST bytes.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ*BYTE_W-1:0]   data_i,
    input  logic [N_REQ-1:0]          last_i,
    output logic [N_REQ-1:0]          gnt_o,
    output logic [N_REQ-1:0]          ack_o,
    output logic [BYTE_W-1:0]         tx_data_o,
    output logic                      tx_valid_o,
    input  logic                      tx_ready_i
);

    localparam int         PTR_W     = $clog2(N_REQ);
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    arb_state_e        state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [PTR_W-1:0]  idx_q, idx_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [7:0]        burst_q, burst_d;

    logic [N_REQ-1:0]  pick;
    logic              pick_any;
    logic [PTR_W-1:0]  pick_idx;
    logic [BYTE_W-1:0] sel_data;
    logic              sel_req;
    logic              sel_last;
    logic              accept;
    logic              burst_done;

    uart_rr_pick #(
        .N  (N_REQ),
        .PW (PTR_W)
    ) u_pick (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .winner_o (pick),
        .any_o    (pick_any)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick[k]) pick_idx = PTR_W'(k);
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (idx_q == PTR_W'(k)) sel_data = data_i[k*BYTE_W +: BYTE_W];
        end
    end

    // Outputs are combinational from the registered grant so a byte can be
    // accepted in the very first granted cycle.
    assign sel_req    = req_i[idx_q];
    assign sel_last   = last_i[idx_q];
    assign tx_valid_o = (state_q == SEND) && sel_req;
    assign tx_data_o  = (state_q == SEND) ? sel_data : '0;
    assign accept     = tx_valid_o && tx_ready_i;
    assign ack_o      = accept ? gnt_q : '0;
    assign gnt_o      = gnt_q;
    assign burst_done = (burst_q + 8'd1) == BURST_MAX;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick;
                    idx_d   = pick_idx;
                    burst_d = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Release on packet end, burst limit, or an abandoned request;
                // the releasing index becomes lowest priority next time.
                if ((accept && (sel_last || burst_done)) || (!accept && !sel_req)) begin
                    gnt_d   = '0;
                    ptr_d   = idx_q;
                    burst_d = '0;
                    state_d = IDLE;
                end else if (accept) begin
                    burst_d = burst_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= PTR_W'(N_REQ - 1);
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: queue-based requesters, a behavioural
// arbitration model checked every cycle, directed scenarios and a random run.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int MB = 16;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic [N-1:0]   req_i = '0;
    logic [8*N-1:0] data_i = '0;
    logic [N-1:0]   last_i = '0;
    logic           tx_ready_i = 1'b0;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   ack_o;
    logic [7:0]     tx_data_o;
    logic           tx_valid_o;

    uart_tx_arb #(
        .N_REQ     (N),
        .MAX_BURST (MB)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .data_i     (data_i),
        .last_i     (last_i),
        .gnt_o      (gnt_o),
        .ack_o      (ack_o),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester byte queues: {last, data}; the front is what is presented.
    logic [8:0] q [N][$];
    int         acc_log [N][$];
    int         all_log [$];
    int         gnt_log [$];
    logic [N-1:0] ack_seen = '0;
    logic [N-1:0] prev_gnt = '0;
    bit         rand_mode  = 1'b0;
    bit         rst_req    = 1'b1;
    int         ready_mode = 3;
    int         cyc        = 0;

    // Behavioural model: owner index (-1 = nobody), last releaser, burst count.
    int   m_owner = -1;
    int   m_ptr   = N - 1;
    int   m_cnt   = 0;
    int   m_c;
    bit   chk_en  = 1'b0;
    logic [N-1:0] e_gnt, e_ack;
    logic         e_valid;
    logic [7:0]   e_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            e_gnt   = '0;
            e_ack   = '0;
            e_valid = 1'b0;
            e_data  = 8'h00;
            if (m_owner >= 0) begin
                e_gnt[m_owner] = 1'b1;
                e_valid        = req_i[m_owner];
                e_data         = data_i[m_owner*8 +: 8];
                if (e_valid && tx_ready_i) e_ack[m_owner] = 1'b1;
            end
            check("gnt", 32'(gnt_o), 32'(e_gnt));
            check("valid", 32'(tx_valid_o), 32'(e_valid));
            check("ack", 32'(ack_o), 32'(e_ack));
            if (m_owner >= 0) check("data", 32'(tx_data_o), 32'(e_data));
            for (int k = 0; k < N; k++) begin
                if (ack_o[k]) begin
                    if (q[k].size() == 0) check("ack_without_byte", 32'd1, 32'd0);
                    else check("sb_byte", 32'(tx_data_o), 32'(q[k][0][7:0]));
                    acc_log[k].push_back(int'(tx_data_o));
                    all_log.push_back(k * 256 + int'(tx_data_o));
                end
            end
            if (gnt_o != '0 && prev_gnt == '0) begin
                for (int k = 0; k < N; k++) if (gnt_o[k]) gnt_log.push_back(k);
            end
            prev_gnt = gnt_o;
        end
        ack_seen = chk_en ? ack_o : '0;

        if (rst_i) begin
            m_owner = -1;
            m_ptr   = N - 1;
            m_cnt   = 0;
            chk_en  = 1'b1;
        end else if (chk_en) begin
            if (m_owner < 0) begin
                for (int i = 1; i <= N; i++) begin
                    m_c = (m_ptr + i) % N;
                    if (m_owner < 0 && req_i[m_c]) m_owner = m_c;
                end
                m_cnt = 0;
            end else if (req_i[m_owner] && tx_ready_i) begin
                m_cnt++;
                if (last_i[m_owner] || m_cnt == MB) begin
                    m_ptr   = m_owner;
                    m_owner = -1;
                    m_cnt   = 0;
                end
            end else if (!req_i[m_owner]) begin
                m_ptr   = m_owner;
                m_owner = -1;
                m_cnt   = 0;
            end
        end
    end

    // One clock: consume acked bytes, drive inputs after the edge, return
    // just after the following falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        rst_i = rst_req;
        for (int k = 0; k < N; k++) begin
            if (ack_seen[k] && q[k].size() > 0) void'(q[k].pop_front());
            req_i[k] = (q[k].size() > 0) && !(rand_mode && $urandom_range(0, 9) == 0);
            data_i[k*8 +: 8] = (q[k].size() > 0) ? q[k][0][7:0] : 8'h00;
            last_i[k]        = (q[k].size() > 0) ? q[k][0][8] : 1'b0;
        end
        case (ready_mode)
            0:       tx_ready_i = ($urandom_range(0, 9) < 6);
            1:       tx_ready_i = (cyc % 10 == 0);
            2:       tx_ready_i = 1'b0;
            default: tx_ready_i = 1'b1;
        endcase
        @(negedge clk);
        #1;
    endtask

    function automatic bit busy();
        bit b = (gnt_o != '0);
        for (int k = 0; k < N; k++) if (q[k].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        check({name, "_drain_timeout"}, 32'(busy()), 32'd0);
    endtask

    task automatic clear_logs();
        all_log.delete();
        gnt_log.delete();
        for (int k = 0; k < N; k++) acc_log[k].delete();
    endtask

    task automatic do_reset();
        for (int k = 0; k < N; k++) q[k].delete();
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        step();
        clear_logs();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lead;
        int bad;
        int n;

        // Reset state
        do_reset();
        check("rst_gnt", 32'(gnt_o), 32'd0);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_valid", 32'(tx_valid_o), 32'd0);
        check("rst_data", 32'(tx_data_o), 32'd0);

        // 3-byte packet from requester 0, TX ready one cycle in ten
        ready_mode = 1;
        q[0].push_back({1'b0, 8'h55});
        q[0].push_back({1'b0, 8'hAA});
        q[0].push_back({1'b1, 8'h0F});
        step();
        check("t1_gnt_latency0", 32'(gnt_o), 32'd0);
        step();
        check("t1_gnt_one_hot", 32'(gnt_o), 32'b0001);
        n = 0;
        while (!(ack_o[0] && tx_data_o == 8'h0F) && n < 60) begin
            step();
            n++;
        end
        check("t1_last_ack_timeout", 32'(n < 60), 32'd1);
        step();
        check("t1_gnt_released", 32'(gnt_o), 32'd0);
        check("t1_ack_count", 32'(acc_log[0].size()), 32'd3);
        if (acc_log[0].size() == 3) begin
            check("t1_byte0", 32'(acc_log[0][0]), 32'h55);
            check("t1_byte1", 32'(acc_log[0][1]), 32'hAA);
            check("t1_byte2", 32'(acc_log[0][2]), 32'h0F);
        end
        drain(50, "t1");

        // Requesters 0 and 2 from reset, 2-byte packets each
        do_reset();
        ready_mode = 3;
        q[0].push_back({1'b0, 8'h11});
        q[0].push_back({1'b1, 8'h12});
        q[2].push_back({1'b0, 8'h21});
        q[2].push_back({1'b1, 8'h22});
        drain(50, "t2");
        check("t2_grants", 32'(gnt_log.size()), 32'd2);
        if (gnt_log.size() == 2) begin
            check("t2_first", 32'(gnt_log[0]), 32'd0);
            check("t2_second", 32'(gnt_log[1]), 32'd2);
        end
        check("t2_bytes", 32'(all_log.size()), 32'd4);
        if (all_log.size() == 4) begin
            check("t2_seq0", 32'(all_log[0]), 32'h011);
            check("t2_seq1", 32'(all_log[1]), 32'h012);
            check("t2_seq2", 32'(all_log[2]), 32'h221);
            check("t2_seq3", 32'(all_log[3]), 32'h222);
        end

        // Requester 1: 20 bytes without last, requester 3 pending
        do_reset();
        for (int i = 0; i < 20; i++) q[1].push_back({1'b0, 8'(8'h80 + i)});
        q[3].push_back({1'b0, 8'hC0});
        q[3].push_back({1'b1, 8'hC1});
        drain(200, "t3");
        lead = 0;
        while (lead < all_log.size() && (all_log[lead] >> 8) == 1) lead++;
        check("t3_burst_len", 32'(lead), 32'd16);
        check("t3_req1_total", 32'(acc_log[1].size()), 32'd20);
        check("t3_grants", 32'(gnt_log.size()), 32'd3);
        if (gnt_log.size() == 3) begin
            check("t3_g0", 32'(gnt_log[0]), 32'd1);
            check("t3_g1", 32'(gnt_log[1]), 32'd3);
            check("t3_g2", 32'(gnt_log[2]), 32'd1);
        end
        if (all_log.size() == 22) begin
            check("t3_req3_after_burst", 32'(all_log[16]), 32'h3C0);
            check("t3_resume", 32'(all_log[18]), 32'h190);
        end

        // TX stalled for 50 cycles while requester 0 holds the grant
        do_reset();
        ready_mode = 2;
        q[0].push_back({1'b1, 8'h5A});
        step();
        step();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!(tx_valid_o === 1'b1 && tx_data_o === 8'h5A && ack_o === 4'b0000 && gnt_o === 4'b0001))
                bad++;
        end
        check("t4_stall_hold", 32'(bad), 32'd0);
        ready_mode = 3;
        step();
        check("t4_first_ready_ack", 32'(ack_o), 32'b0001);
        check("t4_first_ready_data", 32'(tx_data_o), 32'h5A);
        step();
        check("t4_released", 32'(gnt_o), 32'd0);

        // Requester 2 abandons its packet after one byte
        do_reset();
        q[2].push_back({1'b0, 8'h31});
        q[2].push_back({1'b0, 8'h32});
        q[2].push_back({1'b0, 8'h33});
        step();
        step();
        check("t5_first_ack", 32'(acc_log[2].size()), 32'd1);
        q[2].delete();
        step();
        check("t5_gnt_held", 32'(gnt_o), 32'b0100);
        check("t5_no_ack", 32'(ack_o), 32'd0);
        step();
        check("t5_gnt_cleared", 32'(gnt_o), 32'd0);
        q[0].push_back({1'b1, 8'h01});
        q[3].push_back({1'b1, 8'h03});
        step();
        step();
        check("t5_req3_beats_req0", 32'(gnt_o), 32'b1000);
        drain(50, "t5");

        // Reset while requester 1 holds the grant mid-packet
        do_reset();
        ready_mode = 2;
        q[1].push_back({1'b0, 8'hD0});
        q[1].push_back({1'b1, 8'hD1});
        step();
        step();
        check("t6_granted", 32'(gnt_o), 32'b0010);
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        q[0].push_back({1'b1, 8'hE0});
        step();
        check("t6_rst_gnt", 32'(gnt_o), 32'd0);
        check("t6_rst_valid", 32'(tx_valid_o), 32'd0);
        check("t6_rst_ack", 32'(ack_o), 32'd0);
        step();
        check("t6_req0_wins_tie", 32'(gnt_o), 32'b0001);
        ready_mode = 3;
        drain(50, "t6");
        check("t6_d0_resent", 32'(acc_log[1].size() > 0 ? acc_log[1][0] : -1), 32'hD0);

        // Randomised traffic against the model
        do_reset();
        rand_mode  = 1'b1;
        ready_mode = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (q[k].size() == 0 && $urandom_range(0, 7) == 0) begin
                    int len;
                    bit nolast;
                    len    = $urandom_range(1, 20);
                    nolast = ($urandom_range(0, 4) == 0);
                    for (int b = 0; b < len; b++)
                        q[k].push_back({(b == len - 1) && !nolast, 8'($urandom_range(0, 255))});
                end
            end
            step();
        end
        rand_mode  = 1'b0;
        ready_mode = 3;
        drain(2000, "rand");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
